protocol_word_assembler: RTL and testbench

//   Clocked, parametrised successor to the nibble-load command decoder. Accepts
//   the UART command byte stream ({opcode[7:4], payload[3:0]}) and assembles

---
 rtl/protocol_pkg.sv | 17 +
 rtl/protocol_nibble_bank.sv | 63 ++++++
 rtl/protocol_word_assembler.sv | 128 ++++++++++++
 tb/tb_protocol_word_assembler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/protocol_pkg.sv
// Shared constants for the command-byte word assembler: opcodes, nibble limit
// and FSM state encoding.
package protocol_pkg;

    localparam logic [3:0] OP_NOP       = 4'h0;
    localparam logic [3:0] OP_LOAD_BASE = 4'h1;
    localparam logic [3:0] OP_COMMIT    = 4'hE;
    localparam logic [3:0] OP_CLEAR     = 4'hF;

    localparam int unsigned MAX_NIB = 13;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_COLLECT = 2'd1;
    localparam state_t ST_PEND    = 2'd2;

endpackage

// File: rtl/protocol_nibble_bank.sv
// Staging register and loaded-nibble mask with one-hot nibble write decode.
//   clk, reset   : clock, async active-high reset
//   load         : write nib into nibble idx-1 (idx is 1-based, already range-checked)
//   idx, nib     : nibble index and payload
//   clear        : zero staging and mask
//   commit       : zero mask (staging retained)
//   word_c       : staging with this cycle's load applied (value a commit captures)
//   mask_next_c  : mask value after this edge
//   full_c       : this load completes the mask
module protocol_nibble_bank #(
    parameter int unsigned NIB = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [3:0]       idx,
    input  logic [3:0]       nib,
    input  logic             clear,
    input  logic             commit,
    output logic [4*NIB-1:0] word_c,
    output logic [NIB-1:0]   mask_next_c,
    output logic             full_c
);

    logic [4*NIB-1:0] staging;
    logic [NIB-1:0]   mask;
    logic [NIB-1:0]   sel;

    // One-hot select of the nibble being loaded
    always_comb begin
        sel = '0;
        for (int i = 0; i < int'(NIB); i++) begin
            if (load && (int'(idx) == i + 1)) begin
                sel[i] = 1'b1;
            end
        end
    end

    // Staging as it will look after the load; last write wins
    always_comb begin
        word_c = staging;
        for (int i = 0; i < int'(NIB); i++) begin
            if (sel[i]) begin
                word_c[4*i +: 4] = nib;
            end
        end
    end

    // Kept independent of commit so the auto-commit path has no loop
    assign full_c      = load && (&(mask | sel));
    assign mask_next_c = (clear || commit) ? '0 : (mask | sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            staging <= '0;
            mask    <= '0;
        end else begin
            staging <= clear ? '0 : word_c;
            mask    <= mask_next_c;
        end
    end

endmodule

// File: rtl/protocol_word_assembler.sv
// Assembles DATA_W-bit words from {opcode, nibble} command bytes and hands
// committed words out on a valid/ready port; flags illegal opcodes.
//   clk, reset          : clock, async active-high reset
//   in_valid, in_data   : command byte stream
//   in_ready            : combinational, low only while an output word is stalled
//   out_data, out_valid : committed word, held until out_ready
//   out_ready           : consumer accepts word
//   err                 : one-cycle pulse per accepted illegal opcode
module protocol_word_assembler
    import protocol_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter bit          AUTO_COMMIT = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err
);

    localparam int unsigned NIB = DATA_W / 4;

    if ((DATA_W % 4 != 0) || (DATA_W < 4) || (NIB > MAX_NIB)) begin : g_bad_width
        $error("protocol_word_assembler: DATA_W must be a multiple of 4 in 4..52");
    end

    logic [3:0]        op;
    logic [3:0]        pay;
    logic              accept;
    logic              is_load;
    logic              is_commit;
    logic              is_clear;
    logic              is_illegal;
    logic              commit_any;
    logic [DATA_W-1:0] word_c;
    logic [NIB-1:0]    mask_next_c;
    logic              full_c;
    state_t            state;
    state_t            state_next;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign op       = in_data[7:4];
    assign pay      = in_data[3:0];

    // Opcode decode, qualified by the handshake
    assign is_load    = accept && (op >= OP_LOAD_BASE) && (op <= 4'(NIB));
    assign is_commit  = accept && (op == OP_COMMIT);
    assign is_clear   = accept && (op == OP_CLEAR);
    assign is_illegal = accept && (op > 4'(NIB)) && (op < OP_COMMIT);
    assign commit_any = is_commit || (AUTO_COMMIT && full_c);

    protocol_nibble_bank #(
        .NIB (NIB)
    ) u_bank (
        .clk         (clk),
        .reset       (reset),
        .load        (is_load),
        .idx         (op),
        .nib         (pay),
        .clear       (is_clear),
        .commit      (commit_any),
        .word_c      (word_c),
        .mask_next_c (mask_next_c),
        .full_c      (full_c)
    );

    // Output word register; a commit on the take edge keeps out_valid high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= is_illegal;
            if (commit_any) begin
                out_data  <= word_c;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (commit_any) begin
                    state_next = ST_PEND;
                end else if (mask_next_c != '0) begin
                    state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (commit_any) begin
                    state_next = ST_PEND;
                end else if (mask_next_c == '0) begin
                    state_next = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (commit_any) begin
                    state_next = ST_PEND;
                end else if (out_ready) begin
                    state_next = (mask_next_c != '0) ? ST_COLLECT : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_protocol_word_assembler.sv
// Scoreboard bench: one instance with explicit commit, one with auto-commit.
module tb_protocol_word_assembler;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_in_valid, b_in_valid;
    logic [7:0]  a_in_data, b_in_data;
    logic        a_in_ready, b_in_ready;
    logic [15:0] a_out_data, b_out_data;
    logic        a_out_valid, b_out_valid;
    logic        a_out_ready, b_out_ready;
    logic        a_err, b_err;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];
    int err_pend_a = 0;
    int err_pend_b = 0;

    always #5 clk = ~clk;

    protocol_word_assembler #(.DATA_W(16), .AUTO_COMMIT(1'b0)) dut_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .err(a_err)
    );

    protocol_word_assembler #(.DATA_W(16), .AUTO_COMMIT(1'b1)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .err(b_err)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor A: compare each word as it is handed over, track err pulses
    always @(negedge clk) begin
        if (!reset && a_out_valid && a_out_ready) begin
            chk("a_word_expected", 64'(exp_a.size() != 0), 64'(1));
            if (exp_a.size() != 0) chk("a_word", 64'(a_out_data), 64'(exp_a.pop_front()));
        end
        if (!reset && a_err) begin
            chk("a_err_expected", 64'(err_pend_a != 0), 64'(1));
            if (err_pend_a != 0) err_pend_a--;
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (!reset && b_out_valid && b_out_ready) begin
            chk("b_word_expected", 64'(exp_b.size() != 0), 64'(1));
            if (exp_b.size() != 0) chk("b_word", 64'(b_out_data), 64'(exp_b.pop_front()));
        end
        if (!reset && b_err) begin
            chk("b_err_expected", 64'(err_pend_b != 0), 64'(1));
            if (err_pend_b != 0) err_pend_b--;
        end
    end

    // Drive one byte and hold it until accepted; returns 1 ns after the accept edge
    task automatic send(input bit sel, input logic [7:0] b);
        int n;
        logic rdy;
        if (sel) begin b_in_valid = 1'b1; b_in_data = b; end
        else     begin a_in_valid = 1'b1; a_in_data = b; end
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            n++;
            rdy = sel ? b_in_ready : a_in_ready;
        end
        if (!rdy) chk("send_timeout", 64'(n), 64'(0));
        @(posedge clk);
        #1;
        if (sel) b_in_valid = 1'b0;
        else     a_in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(a_out_valid), 64'(0));
        chk("rst_out_data",  64'(a_out_data),  64'(0));
        chk("rst_err",       64'(a_err),       64'(0));
        chk("rst_in_ready",  64'(a_in_ready),  64'(1));
        reset = 1'b0;

        // Full word, one-cycle valid
        exp_a.push_back(16'h4321);
        send(0, 8'h11); send(0, 8'h22); send(0, 8'h33); send(0, 8'h44); send(0, 8'hE0);
        chk("t1_valid_hi", 64'(a_out_valid), 64'(1));
        chk("t1_err", 64'(a_err), 64'(0));
        @(posedge clk); #1;
        chk("t1_valid_lo", 64'(a_out_valid), 64'(0));

        // Partial commit keeps old nibbles; clear then commit gives zero
        exp_a.push_back(16'h4351);
        send(0, 8'h25); send(0, 8'hE0);
        exp_a.push_back(16'h0000);
        send(0, 8'hF0); send(0, 8'hE0);

        // Backpressure: stalled word holds off input; take and accept on same edge
        send(0, 8'h13);
        a_out_ready = 1'b0;
        exp_a.push_back(16'h0003);
        send(0, 8'hE0);
        a_in_valid = 1'b1; a_in_data = 8'h29;
        repeat (3) begin
            @(negedge clk);
            chk("t3_in_ready_lo", 64'(a_in_ready), 64'(0));
            chk("t3_data_stable", 64'(a_out_data), 64'(16'h0003));
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("t3_in_ready_hi", 64'(a_in_ready), 64'(1));
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        chk("t3_taken", 64'(a_out_valid), 64'(0));
        exp_a.push_back(16'h0093);
        send(0, 8'hE0);

        // Back-to-back commits with no bubble
        send(0, 8'h1F);
        exp_a.push_back(16'h009F);
        send(0, 8'hE0);
        exp_a.push_back(16'h009F);
        send(0, 8'hE0);
        chk("t3_b2b_valid", 64'(a_out_valid), 64'(1));
        @(posedge clk); #1;
        chk("t3_b2b_done", 64'(a_out_valid), 64'(0));

        // Illegal opcodes at both ends of the range; state untouched
        err_pend_a++;
        send(0, 8'h57);
        chk("t5_err_hi", 64'(a_err), 64'(1));
        send(0, 8'h00);
        chk("t5_err_lo", 64'(a_err), 64'(0));
        err_pend_a++;
        send(0, 8'hD3);
        chk("t5_err_d", 64'(a_err), 64'(1));
        exp_a.push_back(16'h009F);
        send(0, 8'hE0);
        @(posedge clk); #1;

        // Asynchronous reset with a word pending
        a_out_ready = 1'b0;
        send(0, 8'h11); send(0, 8'h22);
        send(0, 8'hE0);
        chk("t6_pending", 64'(a_out_valid), 64'(1));
        #3;
        reset = 1'b1;
        exp_a.delete();
        #1;
        chk("t6_async_valid", 64'(a_out_valid), 64'(0));
        chk("t6_async_data",  64'(a_out_data),  64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        a_out_ready = 1'b1;
        exp_a.push_back(16'h0000);
        send(0, 8'hE0);

        // Auto-commit instance
        exp_b.push_back(16'hDCBA);
        send(1, 8'h1A); send(1, 8'h2B); send(1, 8'h3C); send(1, 8'h4D);
        chk("t4_auto_valid", 64'(b_out_valid), 64'(1));
        send(1, 8'h19);
        chk("t4_no_commit1", 64'(b_out_valid), 64'(0));
        send(1, 8'h1F);
        chk("t4_no_commit2", 64'(b_out_valid), 64'(0));
        exp_b.push_back(16'hDCBF);
        send(1, 8'hE0);

        repeat (4) @(posedge clk);
        #1;
        chk("end_exp_a_empty", 64'(exp_a.size()), 64'(0));
        chk("end_exp_b_empty", 64'(exp_b.size()), 64'(0));
        chk("end_err_a", 64'(err_pend_a), 64'(0));
        chk("end_err_b", 64'(err_pend_b), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
